// File: rtl/mem_init_pkg.sv
// Shared types and constants for the working-memory initialisation sequencer.
package mem_init_pkg;

  localparam int MEM_DEPTH = 256;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;

  // Highest address. Reaching it ends the WRITE phase.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fsm_mem_w_init.sv
// Initialisation sequencer: on start, writes S[i] = i to all 256 locations,
// one per clock, then raises finish until start is released (4-phase handshake).
module fsm_mem_w_init
  import mem_init_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              finish
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;

  // State and write counter registers; reset returns to IDLE with the counter cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      i_q     <= i_d;
    end
  end

  // Next-state, counter update and Moore output decode (no path from start to outputs).
  always_comb begin
    // NOTE: defaults first so no branch leaves a signal unassigned (no latches).
    state_d = state_q;
    i_d     = i_q;
    wr_en   = 1'b0;
    finish  = 1'b0;

    case (state_q)
      IDLE: begin
        i_d = '0;
        if (start) begin
          state_d = WRITE;
        end
      end

      WRITE: begin
        // start is deliberately ignored here: the sequence always completes.
        wr_en = 1'b1;
        if (i_q == LAST_ADDR) begin
          state_d = DONE;
          i_d     = '0;
        end else begin
          i_d = i_q + 1'b1;
        end
      end

      DONE: begin
        finish = 1'b1;
        // Wait for start to drop so a held request cannot retrigger a second run.
        if (!start) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        i_d     = '0;
      end
    endcase
  end

  // Address and data both track the counter, giving the identity pattern.
  assign mem_addr = i_q;
  assign wr_data  = DATA_W'(i_q);

endmodule

// File: tb/tb_fsm_mem_w_init.sv
// Directed self-checking bench for fsm_mem_w_init. Inputs change and outputs
// are sampled on the falling edge; the DUT acts on the rising edge.
module tb_fsm_mem_w_init;

  logic       clk;
  logic       rst;
  logic       start;
  logic       wr_en;
  logic [7:0] mem_addr;
  logic [7:0] wr_data;
  logic       finish;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Scoreboard RAM fed from the DUT write port.
  logic [7:0] sb_mem     [256];
  logic       sb_written [256];

  fsm_mem_w_init dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .wr_en    (wr_en),
    .mem_addr (mem_addr),
    .wr_data  (wr_data),
    .finish   (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_clear();
    for (int a = 0; a < 256; a++) begin
      sb_mem[a]     = 8'h00;
      sb_written[a] = 1'b0;
    end
  endtask

  // Checks the scoreboard holds S[i] = i everywhere.
  task automatic sb_check(input string tag);
    int bad = 0;
    for (int a = 0; a < 256; a++) begin
      if (!sb_written[a] || sb_mem[a] != 8'(a)) bad++;
    end
    check(tag, bad, 0);
  endtask

  // Called on a falling edge: raises start so the next rising edge is E0,
  // then watches all 256 write cycles. drop_k drops start after cycle k,
  // toggle flips start during addresses 10..20, hold sets start level at the end.
  task automatic do_run(input string tag, input int drop_k, input bit toggle, input bit hold);
    int addr_err = 0;
    int data_err = 0;
    int n_writes = 0;
    start = 1'b1;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        n_writes++;
        sb_mem[mem_addr]     = wr_data;
        sb_written[mem_addr] = 1'b1;
      end
      if (wr_en !== 1'b1 || mem_addr !== 8'(k)) addr_err++;
      if (wr_data !== 8'(k)) data_err++;
      if (finish !== 1'b0) addr_err++;
      if (k == drop_k) start = 1'b0;
      if (toggle && k >= 10 && k <= 20) start = ~start;
      if (k == 255) start = hold;
    end
    check({tag, "_addr_seq"}, addr_err, 0);
    check({tag, "_data_seq"}, data_err, 0);
    check({tag, "_write_cnt"}, n_writes, 256);
    // One clock after address 255: DONE.
    @(negedge clk);
    check({tag, "_finish_rise"}, finish, 1'b1);
    check({tag, "_wr_en_done"}, wr_en, 1'b0);
    check({tag, "_addr_done"}, mem_addr, 8'h00);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sb_clear();

    // ---- Reset ----
    #2;
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_finish", finish, 1'b0);
    check("rst_addr", mem_addr, 8'h00);
    check("rst_data", wr_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    begin
      int idle_writes = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (wr_en !== 1'b0 || finish !== 1'b0) idle_writes++;
      end
      check("idle_quiet", idle_writes, 0);
    end

    // ---- Basic run: start high for 2 edges ----
    do_run("basic", 1, 1'b0, 1'b0);
    sb_check("basic_sb");
    // start already low: DONE -> IDLE at the next edge.
    @(negedge clk);
    check("basic_finish_fall", finish, 1'b0);
    @(negedge clk);
    check("basic_idle_wr_en", wr_en, 1'b0);

    // ---- Handshake: hold start through completion ----
    sb_clear();
    do_run("hs", 300, 1'b0, 1'b1);
    sb_check("hs_sb");
    begin
      int bad = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (finish !== 1'b1 || wr_en !== 1'b0) bad++;
      end
      check("hs_hold_done", bad, 0);
    end
    start = 1'b0;
    @(negedge clk);
    check("hs_finish_fall", finish, 1'b0);
    @(negedge clk);
    check("hs_idle_wr_en", wr_en, 1'b0);
    check("hs_idle_finish", finish, 1'b0);

    // ---- Mid-run reset at address 100 ----
    start = 1'b1;
    begin
      int bad = 0;
      for (int k = 0; k <= 100; k++) begin
        @(negedge clk);
        if (wr_en !== 1'b1 || mem_addr !== 8'(k)) bad++;
      end
      check("mid_pre_seq", bad, 0);
    end
    check("mid_at_100", mem_addr, 8'd100);
    start = 1'b0;
    rst   = 1'b1;
    #1;
    check("mid_async_wr_en", wr_en, 1'b0);
    check("mid_async_addr", mem_addr, 8'h00);
    check("mid_async_finish", finish, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_idle_wr_en", wr_en, 1'b0);
    sb_clear();
    do_run("mid_restart", 1, 1'b0, 1'b0);
    sb_check("mid_restart_sb");
    @(negedge clk);
    check("mid_finish_fall", finish, 1'b0);

    // ---- start toggled during addresses 10..20 ----
    @(negedge clk);
    sb_clear();
    do_run("toggle", 300, 1'b1, 1'b1);
    sb_check("toggle_sb");

    // ---- Back-to-back: drop start for one cycle, then reassert ----
    start = 1'b0;
    @(negedge clk);
    check("b2b_finish_fall", finish, 1'b0);
    check("b2b_gap_wr_en", wr_en, 1'b0);
    sb_clear();
    do_run("b2b", 1, 1'b0, 1'b0);
    sb_check("b2b_sb");
    @(negedge clk);
    check("b2b_end_finish", finish, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no_finish expected finish_before_200000ns");
    $fatal(1, "timeout");
  end

endmodule
